link_frame_scheduler: RTL and testbench

//  Shares the single Manchester downlink (dout) between N_REQ frame requesters (startup probe, power-opt, telemetry).

---
 rtl/link_frame_scheduler.sv | 199 +++++++++++++++++++
 tb/tb_link_frame_scheduler.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/link_frame_scheduler.sv
// link_frame_scheduler
//  Shares one Manchester downlink between N_REQ frame requesters. A round-robin
//  arbiter grants one requester at a time, its FRAME_BITS payload is sent MSB
//  first as Manchester half-bits (bit 1 -> 0,1; bit 0 -> 1,0), and an optional
//  answer window then counts rising edges on din. One done pulse per frame.
// Ports
//  clk, nrst               clock, asynchronous active-low reset
//  swiptAlive, data_start  link enables; either low aborts to IDLE
//  req, frame_in, need_resp  per-requester request, payload, answer-window request
//  din                     detected answer bit (synchronous to clk)
//  grant                   one-hot accept pulse
//  dout, write             Manchester output and frame-on-line flag
//  read                    answer window open
//  done, done_id, resp_cnt completion pulse with requester index and edge count
//  busy                    not idle
//
// state  | meaning
// S_IDLE | waiting for an enabled request; grants in the same cycle
// S_TX   | serialising the latched frame on dout
// S_RX   | answer window, counting din rising edges
// S_DONE | one-cycle completion report
module link_frame_scheduler #(
   parameter int N_REQ      = 3,
   parameter int FRAME_BITS = 20,
   parameter int BIT_TICKS  = 100000,
   parameter int RESP_TICKS = 2500000
) (
   input  logic                          clk,
   input  logic                          nrst,
   input  logic                          swiptAlive,
   input  logic                          data_start,
   input  logic [N_REQ-1:0]              req,
   input  logic [N_REQ*FRAME_BITS-1:0]   frame_in,
   input  logic [N_REQ-1:0]              need_resp,
   input  logic                          din,
   output logic [N_REQ-1:0]              grant,
   output logic                          dout,
   output logic                          write,
   output logic                          read,
   output logic                          done,
   output logic [$clog2(N_REQ)-1:0]      done_id,
   output logic [1:0]                    resp_cnt,
   output logic                          busy
);

   localparam int ID_W   = $clog2(N_REQ);
   localparam int TICK_W = $clog2(BIT_TICKS + 1);
   localparam int HALF_W = $clog2(2 * FRAME_BITS);
   localparam int RESP_W = $clog2(RESP_TICKS + 1);

   typedef enum logic [1:0] {S_IDLE, S_TX, S_RX, S_DONE} state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [ID_W-1:0]         r_rr;
   logic [ID_W-1:0]         r_id;
   logic                    r_need;
   logic [FRAME_BITS-1:0]   r_frame;
   logic [TICK_W-1:0]       r_tick;
   logic [HALF_W-1:0]       r_half;
   logic [RESP_W-1:0]       r_rtick;
   logic                    r_din_prev;
   logic [1:0]              r_cnt;

   logic                    w_en;
   logic                    w_fire;
   logic                    w_found;
   logic [ID_W-1:0]         w_k;
   logic [ID_W:0]           w_sum;
   logic [FRAME_BITS-1:0]   w_slice;
   logic                    w_tick_tc;
   logic                    w_tx_last;

   // Reset is folded in so grant stays low while nrst is asserted even with
   // requests pending.
   assign w_en      = swiptAlive & data_start & nrst;
   assign w_fire    = (r_state == S_IDLE) & w_en & w_found;
   assign w_tick_tc = (r_tick == '0);
   assign w_tx_last = w_tick_tc & (r_half == '0);

   // Search rr, rr+1, ... mod N_REQ; the extra sum bit avoids wrap for
   // non-power-of-two N_REQ.
   always_comb begin
      w_found = 1'b0;
      w_k     = '0;
      w_sum   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         w_sum = {1'b0, r_rr} + (ID_W+1)'(i);
         if (w_sum >= (ID_W+1)'(N_REQ))
            w_sum = w_sum - (ID_W+1)'(N_REQ);
         for (int j = 0; j < N_REQ; j++) begin
            if (!w_found && req[j] && (w_sum == (ID_W+1)'(j))) begin
               w_found = 1'b1;
               w_k     = ID_W'(j);
            end
         end
      end
   end

   always_comb begin
      w_slice = '0;
      for (int j = 0; j < N_REQ; j++) begin
         if (ID_W'(j) == w_k)
            w_slice = frame_in[j*FRAME_BITS +: FRAME_BITS];
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      grant       = '0;
      dout        = 1'b0;
      write       = 1'b0;
      read        = 1'b0;
      done        = 1'b0;
      done_id     = '0;
      resp_cnt    = '0;
      busy        = (r_state != S_IDLE);
      case (r_state)
         S_IDLE: begin
            if (w_fire) begin
               grant[w_k]  = 1'b1;
               w_state_nxt = S_TX;
            end
         end
         S_TX: begin
            write = 1'b1;
            // odd half index = first half of the bit
            dout  = r_half[0] ? ~r_frame[FRAME_BITS-1] : r_frame[FRAME_BITS-1];
            if (w_tx_last)
               w_state_nxt = r_need ? S_RX : S_DONE;
         end
         S_RX: begin
            read = 1'b1;
            if (r_rtick == '0)
               w_state_nxt = S_DONE;
         end
         S_DONE: begin
            if (w_en) begin
               done     = 1'b1;
               done_id  = r_id;
               resp_cnt = r_cnt;
            end
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
      if (!w_en)
         w_state_nxt = S_IDLE;
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_rr       <= '0;
         r_id       <= '0;
         r_need     <= 1'b0;
         r_frame    <= '0;
         r_tick     <= '0;
         r_half     <= '0;
         r_rtick    <= '0;
         r_din_prev <= 1'b0;
         r_cnt      <= '0;
      end else begin
         r_din_prev <= 1'b0;
         if (w_fire) begin
            r_frame <= w_slice;
            r_need  <= need_resp[w_k];
            r_id    <= w_k;
            r_rr    <= (w_k == ID_W'(N_REQ-1)) ? '0 : w_k + 1'b1;
            r_cnt   <= '0;
            r_tick  <= TICK_W'(BIT_TICKS-1);
            r_half  <= HALF_W'(2*FRAME_BITS-1);
         end else if (r_state == S_TX) begin
            if (w_tick_tc) begin
               r_tick <= TICK_W'(BIT_TICKS-1);
               r_half <= r_half - 1'b1;
               if (!r_half[0])
                  r_frame <= {r_frame[FRAME_BITS-2:0], 1'b0};
            end else begin
               r_tick <= r_tick - 1'b1;
            end
            if (w_tx_last) begin
               r_rtick <= RESP_W'(RESP_TICKS-1);
               r_cnt   <= '0;
            end
         end else if (r_state == S_RX) begin
            r_rtick    <= r_rtick - 1'b1;
            r_din_prev <= din;
            if (din && !r_din_prev && (r_cnt != 2'd3))
               r_cnt <= r_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_link_frame_scheduler.sv
// tb_link_frame_scheduler
//  Directed bench for link_frame_scheduler with N_REQ=3, FRAME_BITS=4,
//  BIT_TICKS=2, RESP_TICKS=10. Inputs change 1 ns after a rising edge;
//  outputs are sampled there (and 1 ns after any input change).
module tb_link_frame_scheduler;

   localparam int N_REQ = 3;
   localparam int FB    = 4;
   localparam int BT    = 2;
   localparam int RT    = 10;

   logic              clk;
   logic              nrst;
   logic              swiptAlive;
   logic              data_start;
   logic [N_REQ-1:0]  req;
   logic [N_REQ*FB-1:0] frame_in;
   logic [N_REQ-1:0]  need_resp;
   logic              din;
   logic [N_REQ-1:0]  grant;
   logic              dout;
   logic              write;
   logic              read;
   logic              done;
   logic [1:0]        done_id;
   logic [1:0]        resp_cnt;
   logic              busy;

   int n_pass;
   int n_total;

   link_frame_scheduler #(
      .N_REQ(N_REQ), .FRAME_BITS(FB), .BIT_TICKS(BT), .RESP_TICKS(RT)
   ) dut (
      .clk(clk), .nrst(nrst), .swiptAlive(swiptAlive), .data_start(data_start),
      .req(req), .frame_in(frame_in), .need_resp(need_resp), .din(din),
      .grant(grant), .dout(dout), .write(write), .read(read), .done(done),
      .done_id(done_id), .resp_cnt(resp_cnt), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [11:0] all_o;
      #3;
      all_o = {grant, dout, write, read, done, done_id, resp_cnt, busy};
      n_total++;
      if (all_o !== 12'h000) $display("FAIL reset_init outputs=%h expected=000", all_o);
      else n_pass++;
      #2 nrst = 1'b1;
      tick();
      req = 3'b001; frame_in = 12'h00B; need_resp = 3'b000;
      #1;
      n_total++;
      if (grant !== 3'b001) $display("FAIL reset_pre_grant grant=%b expected=001", grant);
      else n_pass++;
      tick();
      tick(); tick(); tick();
      n_total++;
      if (write !== 1'b1) $display("FAIL reset_pre_write write=%b expected=1", write);
      else n_pass++;
      #2 nrst = 1'b0;
      #1;
      all_o = {grant, dout, write, read, done, done_id, resp_cnt, busy};
      n_total++;
      if (all_o !== 12'h000) $display("FAIL reset_midtx outputs=%h expected=000", all_o);
      else n_pass++;
      req = 3'b000;
      #2 nrst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_total++;
         if (busy !== 1'b0) $display("FAIL reset_idle busy=%b expected=0 cycle=%0d", busy, i);
         else n_pass++;
      end
   endtask

   task automatic test_single_frame();
      logic [15:0] exp_d;
      exp_d = 16'b0011_1100_0011_0011;
      req = 3'b001; frame_in = 12'h00B; need_resp = 3'b000;
      #1;
      n_total++;
      if (grant !== 3'b001) $display("FAIL single_grant grant=%b expected=001", grant);
      else n_pass++;
      for (int i = 0; i < 16; i++) begin
         tick();
         if (i == 0) begin
            req = 3'b000;
            frame_in = 12'h004;
            #1;
         end
         n_total++;
         if (write !== 1'b1 || dout !== exp_d[15-i])
            $display("FAIL single_tx cycle=%0d write=%b dout=%b expected write=1 dout=%b",
                     i, write, dout, exp_d[15-i]);
         else n_pass++;
      end
      tick();
      n_total++;
      if (done !== 1'b1 || done_id !== 2'd0 || resp_cnt !== 2'd0 || write !== 1'b0 || dout !== 1'b0)
         $display("FAIL single_done done=%b id=%0d cnt=%0d write=%b dout=%b expected 1 0 0 0 0",
                  done, done_id, resp_cnt, write, dout);
      else n_pass++;
      tick();
      n_total++;
      if (done !== 1'b0 || busy !== 1'b0) $display("FAIL single_idle done=%b busy=%b expected 0 0", done, busy);
      else n_pass++;
   endtask

   task automatic test_answer_window();
      logic [9:0] pats [3];
      logic [1:0] exp_c [3];
      pats[0] = 10'b0000000000; exp_c[0] = 2'd0;
      pats[1] = 10'b1010101000; exp_c[1] = 2'd3;
      pats[2] = 10'b1000000001; exp_c[2] = 2'd2;
      for (int s = 0; s < 3; s++) begin
         req = 3'b010; need_resp = 3'b010; frame_in = 12'h090;
         #1;
         n_total++;
         if (grant !== 3'b010) $display("FAIL resp_grant scen=%0d grant=%b expected=010", s, grant);
         else n_pass++;
         for (int i = 0; i < 16; i++) begin
            tick();
            if (i == 0) req = 3'b000;
            din = (s == 0 && i == 4) || (s == 2 && i == 15);
            if (i == 15) begin
               n_total++;
               if (read !== 1'b0 || write !== 1'b1)
                  $display("FAIL resp_lasttx scen=%0d read=%b write=%b expected 0 1", s, read, write);
               else n_pass++;
            end
         end
         for (int j = 0; j < RT; j++) begin
            tick();
            n_total++;
            if (read !== 1'b1 || write !== 1'b0)
               $display("FAIL resp_read scen=%0d cycle=%0d read=%b write=%b expected 1 0", s, j, read, write);
            else n_pass++;
            din = pats[s][9-j];
         end
         tick();
         din = 1'b0;
         n_total++;
         if (done !== 1'b1 || done_id !== 2'd1 || resp_cnt !== exp_c[s] || read !== 1'b0)
            $display("FAIL resp_done scen=%0d done=%b id=%0d cnt=%0d read=%b expected 1 1 %0d 0",
                     s, done, done_id, resp_cnt, read, exp_c[s]);
         else n_pass++;
         tick();
         n_total++;
         if (busy !== 1'b0) $display("FAIL resp_idle scen=%0d busy=%b expected=0", s, busy);
         else n_pass++;
      end
      need_resp = 3'b000;
   endtask

   task automatic test_round_robin();
      logic [2:0] exp_g [4];
      int ng;
      int nd;
      logic overlap;
      exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100; exp_g[3] = 3'b001;
      nrst = 1'b0;
      #2 nrst = 1'b1;
      tick();
      req = 3'b111; need_resp = 3'b000;
      #1;
      ng = 0; nd = 0; overlap = 1'b0;
      for (int c = 0; c < 120 && ng < 4; c++) begin
         if (done === 1'b1 && grant !== 3'b000) overlap = 1'b1;
         if (grant !== 3'b000) begin
            n_total++;
            if (grant !== exp_g[ng]) $display("FAIL rr_order idx=%0d grant=%b expected=%b", ng, grant, exp_g[ng]);
            else n_pass++;
            if (ng > 0) begin
               n_total++;
               if (nd != 1) $display("FAIL rr_dones idx=%0d dones=%0d expected=1", ng, nd);
               else n_pass++;
            end
            nd = 0;
            ng++;
         end
         if (done === 1'b1) nd++;
         tick();
      end
      req = 3'b000;
      n_total++;
      if (ng != 4) $display("FAIL rr_timeout grants=%0d expected=4", ng);
      else n_pass++;
      n_total++;
      if (overlap !== 1'b0) $display("FAIL rr_overlap overlap=%b expected=0", overlap);
      else n_pass++;
      for (int c = 0; c < 40 && busy !== 1'b0; c++) tick();
      n_total++;
      if (busy !== 1'b0) $display("FAIL rr_drain busy=%b expected=0", busy);
      else n_pass++;
   endtask

   task automatic test_abort();
      req = 3'b111; need_resp = 3'b000;
      #1;
      n_total++;
      if (grant !== 3'b010) $display("FAIL abort_grant grant=%b expected=010", grant);
      else n_pass++;
      for (int i = 0; i < 7; i++) tick();
      n_total++;
      if (write !== 1'b1) $display("FAIL abort_pre write=%b expected=1", write);
      else n_pass++;
      data_start = 1'b0;
      #1;
      n_total++;
      if (grant !== 3'b000 || done !== 1'b0) $display("FAIL abort_same grant=%b done=%b expected 000 0", grant, done);
      else n_pass++;
      tick();
      n_total++;
      if (write !== 1'b0 || dout !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
         $display("FAIL abort_next write=%b dout=%b busy=%b done=%b expected 0 0 0 0", write, dout, busy, done);
      else n_pass++;
      tick();
      n_total++;
      if (grant !== 3'b000 || busy !== 1'b0) $display("FAIL abort_hold grant=%b busy=%b expected 000 0", grant, busy);
      else n_pass++;
      data_start = 1'b1;
      #1;
      n_total++;
      if (grant !== 3'b100) $display("FAIL abort_resume grant=%b expected=100", grant);
      else n_pass++;
      tick();
      req = 3'b000;
      for (int c = 0; c < 40 && busy !== 1'b0; c++) tick();
      n_total++;
      if (busy !== 1'b0) $display("FAIL abort_drain busy=%b expected=0", busy);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      int g1, d, g2;
      logic have_g1, have_d, have_g2;
      have_g1 = 1'b0; have_d = 1'b0; have_g2 = 1'b0;
      g1 = 0; d = 0; g2 = 0;
      req = 3'b010; need_resp = 3'b000;
      #1;
      n_total++;
      if (grant !== 3'b010) $display("FAIL b2b_grant grant=%b expected=010", grant);
      else n_pass++;
      for (int c = 0; c < 60 && !have_g2; c++) begin
         if (grant !== 3'b000) begin
            if (!have_g1) begin g1 = c; have_g1 = 1'b1; end
            else if (have_d) begin g2 = c; have_g2 = 1'b1; end
         end
         if (done === 1'b1 && have_g1 && !have_d) begin d = c; have_d = 1'b1; end
         tick();
      end
      req = 3'b000;
      n_total++;
      if (!(have_g1 && have_d && have_g2))
         $display("FAIL b2b_timeout g1=%b d=%b g2=%b expected 1 1 1", have_g1, have_d, have_g2);
      else n_pass++;
      n_total++;
      if (d - g1 != 17) $display("FAIL b2b_grant_to_done spacing=%0d expected=17", d - g1);
      else n_pass++;
      n_total++;
      if (g2 - d != 1) $display("FAIL b2b_done_to_grant spacing=%0d expected=1", g2 - d);
      else n_pass++;
      for (int c = 0; c < 40 && busy !== 1'b0; c++) tick();
      n_total++;
      if (busy !== 1'b0) $display("FAIL b2b_drain busy=%b expected=0", busy);
      else n_pass++;
   endtask

   initial begin
      n_pass = 0; n_total = 0;
      nrst = 1'b0; swiptAlive = 1'b1; data_start = 1'b1;
      req = '0; frame_in = '0; need_resp = '0; din = 1'b0;
      test_reset();
      test_single_frame();
      test_answer_window();
      test_round_robin();
      test_abort();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
